reorder_buffer: RTL and testbench

32-entry circular reorder buffer for the out-of-order RISC-V core. It sits directly downstream of rename and allocates one entry per renamed instruction, returning the ROB tag. It marks entries complete from the ALU, memory and branch FU writeback buses, and retires in program order. At retirement it returns `pd_old` to the free list and exposes the head tag to the LSQ. On a branch mispredict it squashes every entry younger than the branch.

---
 rtl/types_pkg.sv | 37 +++
 rtl/reorder_buffer_if.sv | 30 +++
 rtl/reorder_buffer_perf_counters.sv | 21 ++
 rtl/reorder_buffer.sv | 91 +++++++++
 tb/tb_reorder_buffer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/types_pkg.sv
// types_pkg: shared ROB types, sizing constants and pointer-age helper
package types_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_TAG_W = 5;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [ROB_TAG_W:0] rob_cnt_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  pd_new;
    logic [6:0]  pd_old;
  } rename_data;
  typedef struct packed {
    logic     fu_alu_done;
    rob_tag_t rob_fu_alu;
  } alu_data;
  typedef struct packed {
    logic     fu_mem_done;
    rob_tag_t rob_fu_mem;
  } mem_data;
  typedef struct packed {
    logic     fu_b_done;
    rob_tag_t rob_fu_b;
    logic     mispredict;
    rob_tag_t mispredict_tag;
  } b_data;
  typedef struct packed {
    logic        valid;
    logic        complete;
    logic [31:0] pc;
    logic [6:0]  pd_new;
    logic [6:0]  pd_old;
    rob_tag_t    rob_index;
  } rob_data;
  function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
    return tag - head;
  endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: rename alloc, FU writeback, commit and flush signals; master = pipeline side, slave = ROB
interface reorder_buffer_if;
  import types_pkg::*;
  logic       alloc_valid;
  rename_data alloc_data;
  logic       alloc_ready;
  rob_tag_t   alloc_tag;
  alu_data    alu_wb;
  mem_data    mem_wb;
  b_data      b_wb;
  logic       commit_valid;
  rob_tag_t   commit_tag;
  logic [6:0] commit_pd_new;
  logic [6:0] commit_pd_old;
  logic [31:0] commit_pc;
  rob_tag_t   head_tag;
  logic       flush;
  logic       empty;
  logic       full;
  modport master (
    output alloc_valid, alloc_data, alu_wb, mem_wb, b_wb,
    input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_pd_new,
           commit_pd_old, commit_pc, head_tag, flush, empty, full
  );
  modport slave (
    input  alloc_valid, alloc_data, alu_wb, mem_wb, b_wb,
    output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_pd_new,
           commit_pd_old, commit_pc, head_tag, flush, empty, full
  );
endinterface

// File: rtl/reorder_buffer_perf_counters.sv
// rob_perf_counters: wrapping commit and squash counters; clk, rst_n, commit_fire, squash_cnt -> perf_committed, perf_squashed
module rob_perf_counters
  import types_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_fire,
  input  rob_cnt_t    squash_cnt,
  output logic [31:0] perf_committed,
  output logic [31:0] perf_squashed
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_committed <= '0;
      perf_squashed  <= '0;
    end else begin
      perf_committed <= perf_committed + 32'(commit_fire);
      perf_squashed  <= perf_squashed + 32'(squash_cnt);
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: 32-entry circular ROB, in-order retire, mispredict squash; ports clk, rst_n, rob (reorder_buffer_if.slave), perf_committed/perf_squashed only with ROB_PERF_EN
module reorder_buffer
  import types_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  reorder_buffer_if.slave rob
`ifdef ROB_PERF_EN
  ,
  output logic [31:0] perf_committed,
  output logic [31:0] perf_squashed
`endif
);
  rob_data    entries [DEPTH];
  rob_tag_t   head;
  rob_tag_t   tail;
  rob_cnt_t   count;
  logic       mispredict;
  logic       alloc_fire;
  logic       commit_fire;
  rob_tag_t   br_age;
  logic [DEPTH-1:0] squash;
  logic [DEPTH-1:0] done;
  assign rob.full          = count == rob_cnt_t'(DEPTH);
  assign rob.empty         = count == '0;
  assign rob.alloc_ready   = !rob.full && !rob.b_wb.mispredict;
  assign rob.alloc_tag     = tail;
  assign rob.head_tag      = head;
  assign rob.commit_valid  = entries[head].valid && entries[head].complete;
  assign rob.commit_tag    = head;
  assign rob.commit_pd_new = entries[head].pd_new;
  assign rob.commit_pd_old = entries[head].pd_old;
  assign rob.commit_pc     = entries[head].pc;
  // An entry is younger than the branch when its distance from head exceeds the branch's.
  always_comb begin
    mispredict  = rob.b_wb.mispredict;
    alloc_fire  = rob.alloc_valid && rob.alloc_ready;
    commit_fire = rob.commit_valid;
    br_age      = rob_age(rob.b_wb.mispredict_tag, head);
    squash      = '0;
    done        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = mispredict && entries[i].valid && rob_age(rob_tag_t'(i), head) > br_age;
      done[i]   = (rob.alu_wb.fu_alu_done && rob.alu_wb.rob_fu_alu == rob_tag_t'(i)) ||
                  (rob.mem_wb.fu_mem_done && rob.mem_wb.rob_fu_mem == rob_tag_t'(i)) ||
                  (rob.b_wb.fu_b_done && rob.b_wb.rob_fu_b == rob_tag_t'(i));
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rob.flush <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid    <= 1'b0;
        entries[i].complete <= 1'b0;
      end
    end else begin
      head      <= head + rob_tag_t'(commit_fire);
      tail      <= mispredict ? rob.b_wb.mispredict_tag + rob_tag_t'(1) : tail + rob_tag_t'(alloc_fire);
      count     <= mispredict ? rob_cnt_t'(br_age) + rob_cnt_t'(1) - rob_cnt_t'(commit_fire)
                              : count + rob_cnt_t'(alloc_fire) - rob_cnt_t'(commit_fire);
      rob.flush <= mispredict;
      for (int i = 0; i < DEPTH; i++) begin
        if (squash[i] || (commit_fire && head == rob_tag_t'(i)))
          entries[i].valid <= 1'b0;
        else if (entries[i].valid && done[i])
          entries[i].complete <= 1'b1;
        if (alloc_fire && tail == rob_tag_t'(i))
          entries[i] <= '{valid: 1'b1, complete: 1'b0, pc: rob.alloc_data.pc,
                          pd_new: rob.alloc_data.pd_new, pd_old: rob.alloc_data.pd_old,
                          rob_index: tail};
      end
    end
  end
`ifdef ROB_PERF_EN
  rob_cnt_t squash_cnt;
  always_comb squash_cnt = rob_cnt_t'($countones(squash));
  rob_perf_counters u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .commit_fire   (commit_fire),
    .squash_cnt    (squash_cnt),
    .perf_committed(perf_committed),
    .perf_squashed (perf_squashed)
  );
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer
module tb_reorder_buffer;
  import types_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  reorder_buffer_if rif ();
`ifdef ROB_PERF_EN
  logic [31:0] perf_committed;
  logic [31:0] perf_squashed;
`endif
  reorder_buffer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rob  (rif)
`ifdef ROB_PERF_EN
    ,
    .perf_committed(perf_committed),
    .perf_squashed (perf_squashed)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rif.alloc_valid = 1'b0;
    rif.alloc_data  = '0;
    rif.alu_wb      = '0;
    rif.mem_wb      = '0;
    rif.b_wb        = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    #1;
  endtask
  task automatic alloc_n(input int n, input logic [31:0] pc0);
    for (int k = 0; k < n; k++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_data  = '{pc: pc0 + 32'(4 * k), pd_new: 7'(10 + k), pd_old: 7'(40 + k)};
      tick();
    end
    rif.alloc_valid = 1'b0;
    #1;
  endtask
  initial begin
    idle();
    tick();
    do_reset();
    check("rst_ready", rif.alloc_ready, 1);
    check("rst_empty", rif.empty, 1);
    check("rst_full", rif.full, 0);
    check("rst_cv", rif.commit_valid, 0);
    check("rst_flush", rif.flush, 0);
    check("rst_atag", rif.alloc_tag, 0);
    check("rst_htag", rif.head_tag, 0);
    for (int k = 0; k < 3; k++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_data  = '{pc: 32'(4 * k), pd_new: 7'(10 + k), pd_old: 7'(40 + k)};
      #1;
      check("alloc_tag", rif.alloc_tag, k);
      tick();
    end
    idle();
    #1;
    check("count3", dut.count, 3);
    check("cv_none", rif.commit_valid, 0);
    rif.alu_wb = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd2};
    tick();
    rif.alu_wb = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd1};
    #1;
    check("cv_t2only", rif.commit_valid, 0);
    tick();
    idle();
    rif.mem_wb = '{fu_mem_done: 1'b1, rob_fu_mem: 5'd0};
    #1;
    check("cv_t1t2", rif.commit_valid, 0);
    tick();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      check("cm_valid", rif.commit_valid, 1);
      check("cm_tag", rif.commit_tag, k);
      check("cm_pd_old", rif.commit_pd_old, 40 + k);
      check("cm_pc", rif.commit_pc, 4 * k);
      tick();
    end
    check("drain_empty", rif.empty, 1);
    check("drain_cv", rif.commit_valid, 0);
    do_reset();
    alloc_n(32, 32'h100);
    check("fill_full", rif.full, 1);
    check("fill_ready", rif.alloc_ready, 0);
    check("fill_tail", dut.tail, 0);
    rif.alloc_valid = 1'b1;
    rif.alloc_data  = '{pc: 32'hdead, pd_new: 7'd1, pd_old: 7'd2};
    tick();
    check("ovf_count", dut.count, 32);
    check("ovf_tail", dut.tail, 0);
    rif.alu_wb = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd0};
    tick();
    rif.alu_wb = '0;
    #1;
    check("fullcm_cv", rif.commit_valid, 1);
    check("fullcm_ready", rif.alloc_ready, 0);
    tick();
    check("aftcm_ready", rif.alloc_ready, 1);
    check("aftcm_count", dut.count, 31);
    check("aftcm_atag", rif.alloc_tag, 0);
    tick();
    idle();
    #1;
    check("refill_count", dut.count, 32);
    do_reset();
    alloc_n(10, 32'h200);
    rif.b_wb   = '{fu_b_done: 1'b1, rob_fu_b: 5'd4, mispredict: 1'b1, mispredict_tag: 5'd4};
    rif.alu_wb = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd7};
    rif.alloc_valid = 1'b1;
    #1;
    check("mp_ready", rif.alloc_ready, 0);
    tick();
    idle();
    #1;
    check("mp_flush", rif.flush, 1);
    check("mp_tail", dut.tail, 5);
    check("mp_count", dut.count, 5);
    check("mp_t7_cmp", dut.entries[7].complete, 0);
    check("mp_ready1", rif.alloc_ready, 1);
    rif.alu_wb = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd0};
    rif.mem_wb = '{fu_mem_done: 1'b1, rob_fu_mem: 5'd1};
    rif.b_wb   = '{fu_b_done: 1'b1, rob_fu_b: 5'd2, mispredict: 1'b0, mispredict_tag: 5'd0};
    tick();
    idle();
    #1;
    check("mp_flush_off", rif.flush, 0);
    for (int k = 0; k < 3; k++) begin
      check("multi_tag", rif.commit_tag, k);
      check("multi_cv", rif.commit_valid, 1);
      tick();
    end
    check("t3_pending", rif.commit_valid, 0);
    rif.alu_wb = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd3};
    tick();
    idle();
    #1;
    check("t3_cm", rif.commit_tag, 3);
    tick();
    check("br_cm_cv", rif.commit_valid, 1);
    check("br_cm_tag", rif.commit_tag, 4);
    check("br_cm_pd", rif.commit_pd_old, 44);
    tick();
    check("mp_drain", rif.empty, 1);
    alloc_n(4, 32'h300);
    rif.alu_wb = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd5};
    tick();
    idle();
    rif.b_wb = '{fu_b_done: 1'b1, rob_fu_b: 5'd7, mispredict: 1'b1, mispredict_tag: 5'd7};
    rif.alloc_valid = 1'b1;
    #1;
    check("mpc_ready", rif.alloc_ready, 0);
    check("mpc_cv", rif.commit_valid, 1);
    check("mpc_ctag", rif.commit_tag, 5);
    tick();
    idle();
    #1;
    check("mpc_count", dut.count, 2);
    check("mpc_atag", rif.alloc_tag, 8);
    check("mpc_head", rif.head_tag, 6);
    check("mpc_flush", rif.flush, 1);
    alloc_n(18, 32'h400);
    check("live20", dut.count, 20);
`ifdef ROB_PERF_EN
    check("perf_cm", perf_committed, 6);
    check("perf_sq", perf_squashed, 6);
`endif
    do_reset();
    check("mid_empty", rif.empty, 1);
    check("mid_atag", rif.alloc_tag, 0);
    check("mid_htag", rif.head_tag, 0);
    check("mid_cv", rif.commit_valid, 0);
`ifdef ROB_PERF_EN
    check("perf_cm0", perf_committed, 0);
    check("perf_sq0", perf_squashed, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
